// File: rtl/store_buffer.sv
`timescale 1ns/1ps
// store_buffer: posted write buffer between the CPU store port and the RAM write port.
// Stores are acked one cycle after request, then drained to RAM in FIFO order. Each
// completed RAM write pulses an invalidate notification for the instruction caches.
// Ports:
//   clk, resetn                     clock, async active-low reset
//   cpu_valid_i/addr/wdata/wstrb    store request (held until cpu_ready_o)
//   cpu_ready_o                     one-cycle store acknowledge
//   ram_valid_o/addr/wdata/wstrb    head-entry write request to RAM
//   ram_ready_i                     RAM write complete
//   inval_valid_o/inval_addr_o      one-cycle notification of a completed RAM write
//   chk_addr_i/chk_hit_o            combinational read-after-write hazard check
//   empty_o                         nothing buffered and no write in flight
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic [3:0]  cpu_wstrb_i,
    output logic        cpu_ready_o,
    output logic        ram_valid_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    output logic [3:0]  ram_wstrb_o,
    input  logic        ram_ready_i,
    output logic        inval_valid_o,
    output logic [31:0] inval_addr_o,
    input  logic [31:0] chk_addr_i,
    output logic        chk_hit_o,
    output logic        empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            state_q;
    logic [29:0]       addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        strb_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic              cpu_ready_q;
    logic              inval_valid_q;
    logic [31:0]       inval_addr_q;

    logic [AW-1:0]     widx, ridx;
    logic              pop_c, accept_c, push_c;
    logic              hit_c;

    assign widx = wptr_q[AW-1:0];
    assign ridx = rptr_q[AW-1:0];

    // A pop in this cycle frees a slot, so a full buffer may accept in the same cycle.
    assign pop_c    = (state_q == S_REQ) && ram_ready_i;
    assign accept_c = cpu_valid_i && !cpu_ready_q && ((cnt_q < PW'(DEPTH)) || pop_c);
    // Zero-strobe stores are acknowledged but never written anywhere.
    assign push_c   = accept_c && (cpu_wstrb_i != 4'b0000);

    // Pointer, count and occupancy next-state.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        vld_d  = vld_q;
        if (push_c) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (push_c && !pop_c) begin
            cnt_d = cnt_q + PW'(1);
        end else if (pop_c && !push_c) begin
            cnt_d = cnt_q - PW'(1);
        end
        // Clear before set: when full, a same-cycle push reuses the slot being popped.
        if (pop_c) begin
            vld_d[ridx] = 1'b0;
        end
        if (push_c) begin
            vld_d[widx] = 1'b1;
        end
    end

    // Entry storage, pointers and store acknowledge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                strb_q[i] <= '0;
            end
            vld_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            cpu_ready_q <= 1'b0;
        end else begin
            if (push_c) begin
                addr_q[widx] <= cpu_addr_i[31:2];
                data_q[widx] <= cpu_wdata_i;
                strb_q[widx] <= cpu_wstrb_i;
            end
            vld_q       <= vld_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            cpu_ready_q <= accept_c;
        end
    end

    // Drain FSM: present head, pop on ready, then one idle gap cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            inval_valid_q <= 1'b0;
            inval_addr_q  <= '0;
        end else begin
            inval_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cnt_q != '0) begin
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ram_ready_i) begin
                        state_q       <= S_GAP;
                        inval_valid_q <= 1'b1;
                        inval_addr_q  <= {addr_q[ridx], 2'b00};
                    end
                end
                S_GAP: begin
                    state_q <= (cnt_q != '0) ? S_REQ : S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Hazard check against every occupied entry, including the head in flight.
    always_comb begin
        hit_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == chk_addr_i[31:2])) begin
                hit_c = 1'b1;
            end
        end
    end

    // RAM payload is forced to zero outside REQ so idle outputs match reset values.
    assign ram_valid_o   = (state_q == S_REQ);
    assign ram_addr_o    = ram_valid_o ? {addr_q[ridx], 2'b00} : 32'h0;
    assign ram_wdata_o   = ram_valid_o ? data_q[ridx] : 32'h0;
    assign ram_wstrb_o   = ram_valid_o ? strb_q[ridx] : 4'h0;
    assign cpu_ready_o   = cpu_ready_q;
    assign inval_valid_o = inval_valid_q;
    assign inval_addr_o  = inval_addr_q;
    assign chk_hit_o     = hit_c;
    assign empty_o       = (cnt_q == '0) && (state_q != S_REQ);

    // Byte-offset bits carry no meaning for word-granular storage and checks.
    logic unused_c;
    assign unused_c = ^{cpu_addr_i[1:0], chk_addr_i[1:0]};

endmodule
